// File: rtl/lis3dh_pkg.sv
// LIS3DH register map, command constants and sequencer state types shared by
// the accelerometer bring-up/poll sequencer.
package lis3dh_pkg;

  localparam logic [7:0] REG_WHO_AM_I  = 8'h0F;
  localparam logic [7:0] REG_CTRL_REG1 = 8'h20;
  localparam logic [7:0] REG_OUT_X_H   = 8'h29;

  localparam logic [7:0] RD_BIT        = 8'h80;
  localparam logic [7:0] WHO_AM_I_ID   = 8'h33;
  localparam logic [7:0] CTRL_REG1_VAL = 8'h77;  // 400 Hz, X/Y/Z enabled

  // Every transfer is one command byte plus one data byte.
  localparam logic [5:0] XFER_NBITS = 6'd15;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_ID,
    ST_ID_CHK,
    ST_CFG,
    ST_IDLE,
    ST_RDX,
    ST_UPD,
    ST_ERROR
  } seq_state_t;

  // Handshake position inside ID, CFG and RDX.
  typedef enum logic [1:0] {
    PH_REQ,   // waiting for spi_ready to issue the request pulse
    PH_ACK,   // request sent, waiting for spi_ready to drop
    PH_DONE   // transfer running, waiting for spi_ready to return
  } xfer_phase_t;

  function automatic logic [31:0] spi_word(input logic [7:0] cmd, input logic [7:0] wdata);
    return {16'h0000, cmd, wdata};
  endfunction

endpackage

// File: rtl/accel_dir_seq_cycle_timer.sv
// Loadable down-counter with a one-cycle done pulse. A count of zero means
// "not started": the first enabled cycle takes load_val_i as the remaining
// cycle count, so done_o fires in the load_val_i-th enabled cycle.
module cycle_timer #(
  parameter int W = 32
) (
  input  logic         CLK12M,
  input  logic         nrst,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] remain;

  // Remaining-cycle bookkeeping; dropping enable discards any partial count.
  always_comb begin
    remain = (cnt_q == '0) ? load_val_i : cnt_q;
    done_o = en_i && (remain <= W'(1));
    cnt_d  = '0;
    if (en_i && (remain > W'(1))) cnt_d = remain - W'(1);
  end

  // Counter register.
  always_ff @(posedge CLK12M or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/accel_dir_seq.sv
// LIS3DH bring-up and X-axis poll sequencer. Reads WHO_AM_I (with retries),
// writes CTRL_REG1, then periodically reads OUT_X_H and derives a
// hysteresis-filtered swing direction for the POV scroller.
module accel_dir_seq
  import lis3dh_pkg::*;
#(
  parameter int BOOT_CYC  = 60000,
  parameter int POLL_CYC  = 12000,
  parameter int THR       = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic        CLK12M,
  input  logic        nrst,
  output logic [31:0] spi_mosi_data,
  input  logic [31:0] spi_miso_data,
  output logic [5:0]  spi_nbits,
  output logic        spi_request,
  input  logic        spi_ready,
  output logic        direction,
  output logic [7:0]  accel_x,
  output logic        sensor_ok,
  output logic        sensor_err
);

  seq_state_t         state_q, state_d;
  xfer_phase_t        phase_q, phase_d;
  logic [31:0]        mosi_q, mosi_d;
  logic [5:0]         nbits_q, nbits_d;
  logic               req_q, req_d;
  logic               dir_q, dir_d;
  logic signed [7:0]  ax_q, ax_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic [7:0]         retry_q, retry_d;
  logic [7:0]         id_q, id_d;

  logic               xfer_done;
  logic               tmr_en;
  logic [31:0]        tmr_len;
  logic               tmr_done;

  // Only the low byte of a 16-bit transfer carries register data.
  logic               unused_miso;
  assign unused_miso = ^spi_miso_data[31:8];

  // Hysteresis on the signed sample; 9-bit extension keeps -128/+127 exact.
  function automatic logic dir_next(input logic signed [7:0] x, input logic cur);
    logic signed [8:0] xe;
    logic signed [8:0] thr;
    xe  = {x[7], x};
    thr = 9'(THR);
    if (xe > thr)       return 1'b1;
    else if (xe < -thr) return 1'b0;
    else                return cur;
  endfunction

  assign tmr_en  = (state_q == ST_BOOT) || (state_q == ST_IDLE);
  assign tmr_len = (state_q == ST_BOOT) ? 32'(BOOT_CYC) : 32'(POLL_CYC);

  cycle_timer #(.W(32)) u_timer (
    .CLK12M     (CLK12M),
    .nrst       (nrst),
    .en_i       (tmr_en),
    .load_val_i (tmr_len),
    .done_o     (tmr_done)
  );

  // SPI handshake, sequencing and output next-state logic.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    mosi_d    = mosi_q;
    nbits_d   = nbits_q;
    req_d     = 1'b0;
    dir_d     = dir_q;
    ax_d      = ax_q;
    ok_d      = ok_q;
    err_d     = err_q;
    retry_d   = retry_q;
    id_d      = id_q;
    xfer_done = 1'b0;

    // Shared handshake for the three transfer states; the command word is
    // already on spi_mosi_data before the request is raised.
    if ((state_q == ST_ID) || (state_q == ST_CFG) || (state_q == ST_RDX)) begin
      case (phase_q)
        PH_REQ:  if (spi_ready) begin
                   req_d   = 1'b1;
                   phase_d = PH_ACK;
                 end
        PH_ACK:  if (!spi_ready) phase_d = PH_DONE;
        PH_DONE: if (spi_ready) begin
                   xfer_done = 1'b1;
                   phase_d   = PH_REQ;
                 end
        default: phase_d = PH_REQ;
      endcase
    end

    case (state_q)
      ST_BOOT: if (tmr_done) begin
        state_d = ST_ID;
        mosi_d  = spi_word(REG_WHO_AM_I | RD_BIT, 8'h00);
        nbits_d = XFER_NBITS;
      end
      ST_ID: if (xfer_done) begin
        id_d    = spi_miso_data[7:0];
        state_d = ST_ID_CHK;
      end
      ST_ID_CHK: begin
        if (id_q == WHO_AM_I_ID) begin
          state_d = ST_CFG;
          mosi_d  = spi_word(REG_CTRL_REG1, CTRL_REG1_VAL);
        end else begin
          retry_d = retry_q + 8'd1;
          if (retry_q + 8'd1 == 8'(MAX_RETRY)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            dir_d   = 1'b0;
          end else begin
            state_d = ST_BOOT;
          end
        end
      end
      ST_CFG: if (xfer_done) begin
        ok_d    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IDLE: if (tmr_done) begin
        state_d = ST_RDX;
        mosi_d  = spi_word(REG_OUT_X_H | RD_BIT, 8'h00);
      end
      ST_RDX: if (xfer_done) begin
        ax_d    = $signed(spi_miso_data[7:0]);
        state_d = ST_UPD;
      end
      ST_UPD: begin
        dir_d   = dir_next(ax_q, dir_q);
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        err_d = 1'b1;
        dir_d = 1'b0;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State and output registers; reset returns every output to zero at once.
  always_ff @(posedge CLK12M or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_BOOT;
      phase_q <= PH_REQ;
      mosi_q  <= '0;
      nbits_q <= '0;
      req_q   <= 1'b0;
      dir_q   <= 1'b0;
      ax_q    <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mosi_q  <= mosi_d;
      nbits_q <= nbits_d;
      req_q   <= req_d;
      dir_q   <= dir_d;
      ax_q    <= ax_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      id_q    <= id_d;
    end
  end

  assign spi_mosi_data = mosi_q;
  assign spi_nbits     = nbits_q;
  assign spi_request   = req_q;
  assign direction     = dir_q;
  assign accel_x       = ax_q;
  assign sensor_ok     = ok_q;
  assign sensor_err    = err_q;

endmodule

// File: doc/accel_dir_seq.md
# accel_dir_seq

Sensor-side sequencer that sits directly upstream of the POV text scroller. It drives the `spi_master` command interface to bring up the on-board LIS3DH accelerometer and then polls the X axis at a fixed rate. It outputs a hysteresis-filtered swing `direction` bit, which the scroller uses to choose forward or mirrored column order. It replaces the ad-hoc sequencer and adds identity checking, retry and error reporting.

## Interface
Parameters:
- `BOOT_CYC`, 60000: cycles waited after reset before the first SPI access (5 ms at 12 MHz).
- `POLL_CYC`, 12000: cycles between X-axis reads, counted from IDLE entry (1 ms).
- `THR`, 16: signed 8-bit hysteresis threshold, range 1..127.
- `MAX_RETRY`, 3: number of WHO_AM_I attempts before entering ERROR.

Ports:
- `CLK12M`  in  1  system clock, 12 MHz.
- `nrst`  in  1  reset, asynchronous, active-low.
- `spi_mosi_data`  out  32  word to shift out; the low `nbits+1` bits go out MSB first.
- `spi_miso_data`  in  32  received word; the low `nbits+1` bits are valid when `ready` rises.
- `spi_nbits`  out  6  transfer length minus 1.
- `spi_request`  out  1  one-cycle transfer start pulse.
- `spi_ready`  in  1  high when `spi_master` is idle or the transfer is done.
- `direction`  out  1  1 = swing toward +X (mirrored text), 0 = toward −X.
- `accel_x`  out  8  last OUT_X_H sample, two's complement.
- `sensor_ok`  out  1  high after WHO_AM_I passes and CONFIG completes.
- `sensor_err`  out  1  sticky; set when identity fails `MAX_RETRY` times.

## Operation
- Reset values: `spi_mosi_data`=0, `spi_nbits`=0, `spi_request`=0, `direction`=0, `accel_x`=0, `sensor_ok`=0, `sensor_err`=0. The FSM starts in BOOT and all counters are 0.
- All transfers are 16 bits (`spi_nbits`=15). `spi_mosi_data` = {16'h0, cmd[7:0], wdata[7:0]}. For reads, cmd bit 7 = 1 and wdata = 0. The result is `spi_miso_data[7:0]`.
- Handshake for every transfer:
  - Drive `spi_mosi_data` and `spi_nbits` stable, then pulse `spi_request` for 1 cycle, only in a cycle where `spi_ready`=1.
  - Wait until `spi_ready`=0 (acknowledge), then wait until `spi_ready`=1 (done).
  - Capture `spi_miso_data` in the cycle `spi_ready` is first seen high.
  - Keep `spi_mosi_data` and `spi_nbits` unchanged from the request until done.
- FSM states:
  - BOOT: count `BOOT_CYC`, then go to ID.
  - ID: transfer cmd 0x8F (read WHO_AM_I). Go to ID_CHK.
  - ID_CHK:
    - data = 0x33: go to CFG.
    - Otherwise increment the retry count. If retries = `MAX_RETRY`, go to ERROR. Else go to BOOT (full boot wait again).
  - CFG: transfer {0x20, 0x77} (CTRL_REG1: 400 Hz, XYZ enabled). On done, set `sensor_ok`=1 and go to IDLE.
  - IDLE: count `POLL_CYC`, then go to RDX.
  - RDX: transfer cmd 0xA9 (read OUT_X_H). On done, load `accel_x` and go to UPD.
  - UPD: update `direction`, then go to IDLE.
  - ERROR: terminal until reset. Set `sensor_err`=1, hold `direction`=0, issue no requests.
- Direction rule, on signed 8-bit `accel_x`:
  - `accel_x` > +`THR`: `direction`=1.
  - `accel_x` < −`THR`: `direction`=0.
  - Otherwise hold the previous value. Equality with ±`THR` holds.
- Comparisons use 9-bit sign-extended arithmetic, so −128 and +127 never overflow.
- If `spi_ready` is low when a request is due, keep waiting in the same state. Never pulse `spi_request` while `spi_ready`=0.

## Timing
- `direction` changes 1 cycle after the RDX done cycle (the UPD cycle). `accel_x` changes in the done cycle.
- Request cadence: one RDX request every `POLL_CYC` + transfer time + 2 cycles.
- First SPI request: cycle `BOOT_CYC`+1 after reset release.
- `sensor_ok` rises in the CFG done cycle. `sensor_err` rises on the cycle the FSM enters ERROR.
- Reset asserted mid-transfer: all outputs return to reset values immediately (async). After release the FSM restarts from BOOT. Any `spi_master` transfer in flight is not tracked.

## Structure
- Shared package `lis3dh_pkg`:
  - Register addresses: WHO_AM_I 0x0F, CTRL_REG1 0x20, OUT_X_H 0x29.
  - Constants: read bit 0x80, expected ID 0x33, CTRL_REG1 value 0x77.
  - The FSM state enum.
- One sub-module, `cycle_timer`: a loadable down-counter with a `done` pulse, shared by BOOT and IDLE.
- Everything else lives in `accel_dir_seq`.

## Test plan
- Reset: hold `nrst`=0 with random inputs → all outputs 0. First request at cycle `BOOT_CYC`+1 after release, with `spi_mosi_data`=0x0000_8F00 and `spi_nbits`=15.
- Bring-up: SPI model returns 0x33 → next request carries 0x0000_2077. `sensor_ok`=1 at its done cycle, followed by a 0x0000_A900 read every poll period.
- Hysteresis (`THR`=16): X sequence 0x30, 0x10, 0x05, 0xF0, 0xE0, 0x80 → `direction` 1, 1, 1, 1, 0, 0, each updating one cycle after done.
- Bad ID: model returns 0x00 three times → three BOOT/ID cycles. `sensor_err`=1, `sensor_ok`=0, and no further `spi_request`.
- Slow master: hold `spi_ready`=0 for 500 cycles after RDX becomes due → no request pulse. Exactly one pulse after `spi_ready` rises, and `spi_mosi_data` stays stable until done.
- Reset during the RDX transfer: all outputs go to 0 immediately, and the full boot sequence repeats.
